// File: rtl/idc_sched.sv
`default_nettype none
// ============================================================================
// Module   : idc_sched
// Purpose  : Round-robin scheduler that shares one ID checker datapath
//            between NUM_REQ requesters. A granted requester's complete
//            ID_LEN-word ID is captured, streamed to the checker one 6-bit
//            word per cycle, and the checker verdict is returned as a tagged
//            one-cycle response.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            req_i / req_id_i    - per-requester request flags / flat IDs
//            req_ready_o         - one-hot one-cycle grant pulse
//            chk_in_valid_o/id_o - word stream towards the checker
//            chk_out_valid_i/
//            chk_out_legal_i     - checker verdict
//            rsp_valid_o/src_o/
//            legal_o/err_o       - tagged response to the requester
//            busy_o              - high whenever not idle
// Options  : IDC_SCHED_TIMEOUT_EN - when defined, a WAIT that lasts TIMEOUT
//            cycles without a verdict ends with an error response.
// Revision : 1.0 - initial release
// ============================================================================
module idc_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_LEN  = 10,
  parameter int TIMEOUT = 16,
  parameter int SW      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ID_LEN*6-1:0]   req_id_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          chk_in_valid_o,
  output logic [5:0]                    chk_in_id_o,
  input  logic                          chk_out_valid_i,
  input  logic                          chk_out_legal_i,
  output logic                          rsp_valid_o,
  output logic [SW-1:0]                 rsp_src_o,
  output logic                          rsp_legal_o,
  output logic                          rsp_err_o,
  output logic                          busy_o
);

  localparam int IDW = ID_LEN * 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  rr_q, rr_d;
  logic [SW-1:0]  owner_q, owner_d;
  logic [IDW-1:0] shreg_q, shreg_d;
  logic [3:0]     wcnt_q, wcnt_d;
  logic [SW-1:0]  rsp_src_q, rsp_src_d;
  logic           rsp_legal_q, rsp_legal_d;

`ifdef IDC_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic           rsp_err_q, rsp_err_d;
`endif

  // --------------------------------------------------------------------------
  // Round-robin arbitration: scan from rr_q upwards, wrapping modulo NUM_REQ,
  // and take the first requester with its flag set.
  // --------------------------------------------------------------------------
  logic          win_found;
  logic [SW-1:0] win_idx;
  logic [SW:0]   arb_sum;

  always_comb begin : p_arb
    win_found = 1'b0;
    win_idx   = '0;
    arb_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_sum = {1'b0, rr_q} + (SW+1)'(i);
      if (arb_sum >= (SW+1)'(NUM_REQ)) begin
        arb_sum = arb_sum - (SW+1)'(NUM_REQ);
      end
      if (!win_found && req_i[arb_sum[SW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = arb_sum[SW-1:0];
      end
    end
  end

  // ID of the current winner, selected with constant slices only.
  logic [IDW-1:0] sel_id;

  always_comb begin : p_sel
    sel_id = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (win_idx == SW'(r)) begin
        sel_id = req_id_i[r*IDW +: IDW];
      end
    end
  end

  // Grant pulse is gated by rst_n so that every output reads 0 while reset
  // is held, even if requesters keep their flags raised.
  always_comb begin : p_ready
    req_ready_o = '0;
    if ((state_q == S_IDLE) && win_found && rst_n) begin
      req_ready_o[win_idx] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin : p_next
    state_d        = state_q;
    rr_d           = rr_q;
    owner_d        = owner_q;
    shreg_d        = shreg_q;
    wcnt_d         = wcnt_q;
    rsp_src_d      = rsp_src_q;
    rsp_legal_d    = rsp_legal_q;
    chk_in_valid_o = 1'b0;
    chk_in_id_o    = 6'd0;
    rsp_valid_o    = 1'b0;
    busy_o         = 1'b1;
`ifdef IDC_SCHED_TIMEOUT_EN
    tcnt_d         = tcnt_q;
    rsp_err_d      = rsp_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (win_found) begin
          state_d = S_ISSUE;
          owner_d = win_idx;
          shreg_d = sel_id;
          wcnt_d  = 4'd0;
          rr_d    = (win_idx == SW'(NUM_REQ - 1)) ? '0 : win_idx + SW'(1);
        end
      end

      S_ISSUE: begin
        // Word 0 sits in the low bits; shifting right exposes the next word.
        chk_in_valid_o = 1'b1;
        chk_in_id_o    = shreg_q[5:0];
        shreg_d        = shreg_q >> 6;
        if (wcnt_q == 4'(ID_LEN - 1)) begin
          wcnt_d  = 4'd0;
          state_d = S_WAIT;
`ifdef IDC_SCHED_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end

      S_WAIT: begin
        if (chk_out_valid_i) begin
          rsp_src_d   = owner_q;
          rsp_legal_d = chk_out_legal_i;
          state_d     = S_RESP;
`ifdef IDC_SCHED_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          // This WAIT cycle is the TIMEOUT-th without a verdict.
          rsp_src_d   = owner_q;
          rsp_legal_d = 1'b0;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
`endif
        end
      end

      S_RESP: begin
        rsp_valid_o = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin : p_state
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_regs
    if (!rst_n) begin
      rr_q        <= '0;
      owner_q     <= '0;
      shreg_q     <= '0;
      wcnt_q      <= 4'd0;
      rsp_src_q   <= '0;
      rsp_legal_q <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      shreg_q     <= shreg_d;
      wcnt_q      <= wcnt_d;
      rsp_src_q   <= rsp_src_d;
      rsp_legal_q <= rsp_legal_d;
    end
  end

  assign rsp_src_o   = rsp_src_q;
  assign rsp_legal_o = rsp_legal_q;

`ifdef IDC_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin : p_tmo
    if (!rst_n) begin
      tcnt_q    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_idc_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_idc_sched
// Purpose  : Self-checking bench for idc_sched. A transaction-level model
//            (grant cycle, word schedule, verdict cycle) predicts every output
//            on every cycle; directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idc_sched;

  localparam int N   = 4;
  localparam int LEN = 10;
  localparam int TO  = 16;
  localparam int SW  = 2;
  localparam int IDW = LEN * 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*IDW-1:0] req_id = '0;
  logic [N-1:0]     req_ready;
  logic             chk_in_valid;
  logic [5:0]       chk_in_id;
  logic             chk_out_valid = 1'b0;
  logic             chk_out_legal = 1'b0;
  logic             rsp_valid;
  logic [SW-1:0]    rsp_src;
  logic             rsp_legal;
  logic             rsp_err;
  logic             busy;

  idc_sched #(.NUM_REQ(N), .ID_LEN(LEN), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_i           (req),
    .req_id_i        (req_id),
    .req_ready_o     (req_ready),
    .chk_in_valid_o  (chk_in_valid),
    .chk_in_id_o     (chk_in_id),
    .chk_out_valid_i (chk_out_valid),
    .chk_out_legal_i (chk_out_legal),
    .rsp_valid_o     (rsp_valid),
    .rsp_src_o       (rsp_src),
    .rsp_legal_o     (rsp_legal),
    .rsp_err_o       (rsp_err),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Transaction-level model
  // --------------------------------------------------------------------------
  bit         m_active = 0;
  int         m_g = 0;
  int         m_rsp = -1;
  int         m_rr = 0;
  int         m_owner = 0;
  logic [5:0] m_word [LEN];
  int         m_src = 0;
  bit         m_legal = 0;
  bit         m_err = 0;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // Observation logs for the directed literal checks
  int         g_cyc[$];
  int         g_vec[$];
  int         r_cyc[$];
  int         r_src[$];
  int         r_leg[$];
  int         r_err[$];
  logic [5:0] ids[$];

  task automatic clear_obs();
    g_cyc.delete(); g_vec.delete();
    r_cyc.delete(); r_src.delete(); r_leg.delete(); r_err.delete();
    ids.delete();
  endtask

  logic [N-1:0] e_ready;
  bit           e_valid;
  logic [5:0]   e_id;
  bit           e_rsp;
  int           mk;
  int           mw;

  // Compare process: runs every cycle, 2 time units after the falling edge.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_chk_in_valid", chk_in_valid, 0);
      chk("rst_chk_in_id", chk_in_id, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_src", rsp_src, 0);
      chk("rst_rsp_legal", rsp_legal, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_busy", busy, 0);
      m_active = 0; m_rr = 0; m_rsp = -1;
      m_src = 0; m_legal = 0; m_err = 0;
    end else begin
      if (chk_in_valid) ids.push_back(chk_in_id);
      if (|req_ready) begin g_cyc.push_back(cyc); g_vec.push_back(int'(req_ready)); end
      if (rsp_valid) begin
        r_cyc.push_back(cyc); r_src.push_back(int'(rsp_src));
        r_leg.push_back(int'(rsp_legal)); r_err.push_back(int'(rsp_err));
      end

      e_ready = '0; e_valid = 0; e_id = '0; e_rsp = 0; mw = -1; mk = 0;
      if (m_active) begin
        mk = cyc - m_g;
        if (mk >= 1 && mk <= LEN) begin
          e_valid = 1;
          e_id    = m_word[mk-1];
        end
        e_rsp = (cyc == m_rsp);
      end else begin
        mw = rr_pick(req, m_rr);
        if (mw >= 0) e_ready[mw] = 1'b1;
      end

      chk("req_ready", req_ready, e_ready);
      chk("chk_in_valid", chk_in_valid, e_valid);
      chk("chk_in_id", chk_in_id, e_id);
      chk("rsp_valid", rsp_valid, e_rsp);
      chk("busy", busy, m_active);
      chk("rsp_src", rsp_src, m_src);
      chk("rsp_legal", rsp_legal, m_legal);
      chk("rsp_err", rsp_err, m_err);

      if (m_active) begin
        if (cyc == m_rsp) begin
          m_active = 0;
        end else if (m_rsp < 0 && mk > LEN) begin
          if (chk_out_valid) begin
            m_rsp = cyc + 1; m_src = m_owner; m_legal = chk_out_legal; m_err = 0;
          end
`ifdef IDC_SCHED_TIMEOUT_EN
          else if (mk == LEN + TO) begin
            m_rsp = cyc + 1; m_src = m_owner; m_legal = 0; m_err = 1;
          end
`endif
        end
      end else if (mw >= 0) begin
        m_active = 1; m_g = cyc; m_rsp = -1; m_owner = mw;
        for (int j = 0; j < LEN; j++) m_word[j] = req_id[mw*IDW + 6*j +: 6];
        m_rr = (mw + 1) % N;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stub checker: verdict LEN+lat cycles after grant, optional spurious pulses
  // --------------------------------------------------------------------------
  bit stub_rand = 0;
  bit stub_never = 0;
  bit stub_spur = 0;
  int stub_lat = 1;
  bit stub_legal = 1;
  int cur_lat = 1;
  bit cur_leg = 1;

  always @(negedge clk) begin
    int kk;
    kk = m_active ? (cyc - m_g) : -1;
    if (m_active && kk == 1) begin
      cur_lat = stub_rand ? int'($urandom_range(1, 6)) : stub_lat;
      cur_leg = stub_rand ? bit'($urandom_range(0, 1)) : stub_legal;
    end
    chk_out_valid = 1'b0;
    chk_out_legal = 1'b0;
    if (m_active && !stub_never && kk == LEN + cur_lat) begin
      chk_out_valid = 1'b1;
      chk_out_legal = cur_leg;
    end else if (stub_spur && (!m_active || kk <= LEN)) begin
      chk_out_valid = 1'b1;
      chk_out_legal = 1'b0;
    end else if (stub_rand && $urandom_range(0, 9) == 0) begin
      chk_out_valid = 1'b1;
      chk_out_legal = 1'($urandom_range(0, 1));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic set_id(input int r, input int base);
    for (int j = 0; j < LEN; j++) req_id[r*IDW + 6*j +: 6] = 6'(base + j);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_bound", busy, 0);
  endtask

  task automatic send(input logic [N-1:0] r);
    clear_obs();
    req = r;
    @(negedge clk);
    req = '0;
    wait_idle();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #3 chk("reset_busy_lit", busy, 0);
    chk("reset_chk_in_valid_lit", chk_in_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, word order, legal verdict
    set_id(0, 1);
    stub_lat = 1; stub_legal = 1;
    send(4'b0001);
    chk("t1_ngrant", g_cyc.size(), 1);
    chk("t1_nwords", ids.size(), 10);
    chk("t1_nrsp", r_cyc.size(), 1);
    if (g_cyc.size() == 1 && r_cyc.size() == 1) begin
      chk("t1_grant_vec", g_vec[0], 1);
      chk("t1_rsp_latency", r_cyc[0] - g_cyc[0], 12);
      chk("t1_rsp_src", r_src[0], 0);
      chk("t1_rsp_legal", r_leg[0], 1);
      chk("t1_rsp_err", r_err[0], 0);
    end
    if (ids.size() == 10) for (int j = 0; j < 10; j++) chk("t1_word", ids[j], j + 1);

    // Illegal verdict
    stub_legal = 0;
    send(4'b0001);
    chk("t2_nrsp", r_cyc.size(), 1);
    if (r_cyc.size() == 1) begin
      chk("t2_rsp_legal", r_leg[0], 0);
      chk("t2_rsp_err", r_err[0], 0);
      chk("t2_rsp_src", r_src[0], 0);
    end
    stub_legal = 1;

    // Round robin from reset with all requesters active
    apply_reset();
    for (int r = 0; r < N; r++) set_id(r, 10 * r + 3);
    clear_obs();
    req = 4'b1111;
    repeat (60) @(negedge clk);
    req = '0;
    wait_idle();
    chk("t3_ngrant", g_cyc.size(), 5);
    if (g_cyc.size() == 5) begin
      chk("t3_g0", g_vec[0], 4'b0001);
      chk("t3_g1", g_vec[1], 4'b0010);
      chk("t3_g2", g_vec[2], 4'b0100);
      chk("t3_g3", g_vec[3], 4'b1000);
      chk("t3_g4", g_vec[4], 4'b0001);
      for (int i = 1; i < 5; i++) chk("t3_period", g_cyc[i] - g_cyc[i-1], 13);
    end

    // Spurious verdicts in IDLE and ISSUE are ignored
    stub_spur = 1; stub_lat = 2; stub_legal = 1;
    set_id(1, 40);
    repeat (3) @(negedge clk);
    send(4'b0010);
    stub_spur = 0;
    chk("t4_nrsp", r_cyc.size(), 1);
    chk("t4_nwords", ids.size(), 10);
    if (r_cyc.size() == 1 && g_cyc.size() == 1) begin
      chk("t4_rsp_src", r_src[0], 1);
      chk("t4_rsp_legal", r_leg[0], 1);
      chk("t4_rsp_latency", r_cyc[0] - g_cyc[0], 13);
    end
    if (ids.size() == 10) chk("t4_word0", ids[0], 40);
    stub_lat = 1;

    // Reset while word 5 is on the bus
    set_id(0, 11);
    clear_obs();
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    repeat (5) @(negedge clk);
    #1;
    chk("t5_word5_valid", chk_in_valid, 1);
    chk("t5_word5_id", chk_in_id, 16);
    rst_n = 1'b0;
    #2;
    chk("t5_async_valid", chk_in_valid, 0);
    chk("t5_words_before", ids.size(), 5);
    repeat (2) @(negedge clk);
    chk("t5_no_rsp", r_cyc.size(), 0);
    set_id(2, 31);
    rst_n = 1'b1;
    clear_obs();
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    wait_idle();
    chk("t5_nrsp", r_cyc.size(), 1);
    chk("t5_nwords", ids.size(), 10);
    if (g_cyc.size() == 1) chk("t5_grant_vec", g_vec[0], 4'b0100);
    if (r_cyc.size() == 1) chk("t5_rsp_src", r_src[0], 2);
    if (ids.size() == 10) begin
      chk("t5_word0", ids[0], 31);
      chk("t5_word9", ids[9], 40);
    end

`ifdef IDC_SCHED_TIMEOUT_EN
    // Checker never answers
    stub_never = 1;
    send(4'b0001);
    stub_never = 0;
    chk("t6_nrsp", r_cyc.size(), 1);
    if (r_cyc.size() == 1 && g_cyc.size() == 1) begin
      chk("t6_rsp_latency", r_cyc[0] - g_cyc[0], 27);
      chk("t6_rsp_err", r_err[0], 1);
      chk("t6_rsp_legal", r_leg[0], 0);
    end
`endif

    // Randomized traffic, checked every cycle by the model
    stub_rand = 1;
    for (int t = 0; t < 1500; t++) begin
      logic [N-1:0] nr;
      @(negedge clk);
      nr = ($urandom_range(0, 3) == 0) ? '0 : 4'($urandom_range(0, 15));
      for (int r = 0; r < N; r++) begin
        if (!nr[r]) begin
          for (int j = 0; j < LEN; j++) req_id[r*IDW + 6*j +: 6] = 6'($urandom_range(0, 63));
        end
      end
      req = nr;
    end
    req = '0;
    stub_rand = 0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
